// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- memory BIST controller: FSM encoding and
// the per-element direction, operation and data-background tables.
package mbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int NUM_ELEMS = 6;
    localparam int ELEM_W    = 3;

    typedef logic [ELEM_W-1:0] elem_t;

    localparam elem_t LAST_ELEM = elem_t'(NUM_ELEMS - 1);

    // Bit i describes March element Mi. M0 is write-only, M5 is read-only,
    // M1..M4 are read-then-write pairs; M3/M4 walk the address space downwards.
    localparam logic [NUM_ELEMS-1:0] ELEM_DOWN      = 6'b011000;
    localparam logic [NUM_ELEMS-1:0] ELEM_HAS_READ  = 6'b111110;
    localparam logic [NUM_ELEMS-1:0] ELEM_HAS_WRITE = 6'b011111;
    localparam logic [NUM_ELEMS-1:0] ELEM_RVAL      = 6'b010100;
    localparam logic [NUM_ELEMS-1:0] ELEM_WVAL      = 6'b001010;

endpackage

// File: rtl/mbist_cmp.sv
// Read-compare path: two-stage tag pipeline matching the memory read latency,
// first-fail capture and a saturating miscompare counter.
module mbist_cmp
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  rd_issue,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  elem_t                 rd_elem,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output elem_t                 fail_elem,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    output logic [CNT_WIDTH-1:0]  error_count
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] exp;
        logic [ADDR_WIDTH-1:0] addr;
        elem_t                 elem;
    } rd_tag_t;

    logic    s1_valid, s2_valid;
    rd_tag_t s1_tag, s2_tag;
    logic    miscompare;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= rd_issue;
            s2_valid <= s1_valid;
        end
    end

    // NOTE: tag payload is qualified by the valid bits, so it carries no reset;
    // only control state needs a known value out of reset.
    always_ff @(posedge clk) begin
        s1_tag <= '{exp: rd_exp, addr: rd_addr, elem: rd_elem};
        s2_tag <= s1_tag;
    end

    assign miscompare = s2_valid && (mem_rdata != s2_tag.exp);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_elem   <= '0;
            fail_exp    <= '0;
            fail_act    <= '0;
            error_count <= '0;
        end else if (miscompare) begin
            if (!fail) begin
                fail_addr <= s2_tag.addr;
                fail_elem <= s2_tag.elem;
                fail_exp  <= s2_tag.exp;
                fail_act  <= mem_rdata;
            end
            fail <= 1'b1;
            if (error_count != {CNT_WIDTH{1'b1}}) begin
                error_count <= error_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer: walks six March elements over the whole address
// space, one memory operation per cycle, and feeds reads to the compare path.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state, state_n;
    elem_t                 elem, elem_n, next_elem;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    logic                  phase, phase_n;
    logic                  drain_cnt, drain_cnt_n;
    logic                  last_addr, is_read;
    logic                  rd_issue, cmp_clear;
    logic [DATA_WIDTH-1:0] rd_exp;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            elem      <= '0;
            addr      <= '0;
            phase     <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_n;
            elem      <= elem_n;
            addr      <= addr_n;
            phase     <= phase_n;
            drain_cnt <= drain_cnt_n;
        end
    end

    assign next_elem = elem + elem_t'(1);
    assign last_addr = ELEM_DOWN[elem] ? (addr == '0) : (addr == {ADDR_WIDTH{1'b1}});
    // Read-write elements read in phase 0 and write the same address in phase 1.
    assign is_read   = ELEM_HAS_READ[elem] && (!ELEM_HAS_WRITE[elem] || !phase);
    assign rd_exp    = {DATA_WIDTH{ELEM_RVAL[elem]}};

    // NOTE: every output and next-state value gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_n        = state;
        elem_n         = elem;
        addr_n         = addr;
        phase_n        = phase;
        drain_cnt_n    = drain_cnt;
        busy           = 1'b0;
        done           = 1'b0;
        mem_write_read = 1'b0;
        mem_address    = '0;
        mem_wdata      = '0;
        rd_issue       = 1'b0;
        cmp_clear      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_SETUP;
                    elem_n  = '0;
                    addr_n  = '0;
                    phase_n = 1'b0;
                end
            end
            ST_SETUP: begin
                busy      = 1'b1;
                cmp_clear = 1'b1;
                mem_wdata = {DATA_WIDTH{ELEM_WVAL[elem]}};
                state_n   = ST_RUN;
            end
            ST_RUN: begin
                busy           = 1'b1;
                mem_address    = addr;
                mem_wdata      = {DATA_WIDTH{ELEM_WVAL[elem]}};
                mem_write_read = !is_read;
                rd_issue       = is_read;
                if (ELEM_HAS_READ[elem] && ELEM_HAS_WRITE[elem] && !phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    if (!last_addr) begin
                        addr_n = ELEM_DOWN[elem] ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
                    end else if (elem == LAST_ELEM) begin
                        state_n     = ST_DRAIN;
                        drain_cnt_n = 1'b0;
                        addr_n      = '0;
                    end else begin
                        elem_n = next_elem;
                        addr_n = ELEM_DOWN[next_elem] ? {ADDR_WIDTH{1'b1}} : '0;
                    end
                end
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                drain_cnt_n = 1'b1;
                if (drain_cnt) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    mbist_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clear      (cmp_clear),
        .rd_issue   (rd_issue),
        .rd_exp     (rd_exp),
        .rd_addr    (addr),
        .rd_elem    (elem),
        .mem_rdata  (mem_rdata),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_elem  (fail_elem),
        .fail_exp   (fail_exp),
        .fail_act   (fail_act),
        .error_count(error_count)
    );

endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width; tested range 0 .. 2**ADDR_WIDTH-1 (N words).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, error counter width.
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  run request, sampled only in IDLE.
REQ-008 busy  out  1  test in progress (SETUP through DRAIN).
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 fail  out  1  sticky: at least one read miscompare this run.
REQ-011 fail_addr  out  ADDR_WIDTH  address of first miscompare.
REQ-012 fail_elem  out  3  March element index (0-5) of first miscompare.
REQ-013 fail_exp / fail_act  out  DATA_WIDTH each  expected/actual word of first miscompare.
REQ-014 error_count  out  CNT_WIDTH  saturating miscompare count.
REQ-015 mem_write_read  out  1  1 = write, 0 = read, to memory write_read.
REQ-016 mem_address  out  ADDR_WIDTH  memory address.
REQ-017 mem_wdata  out  DATA_WIDTH  memory write data.
REQ-018 mem_rdata  in  DATA_WIDTH  memory read data.

Function
REQ-019 SHALL execute March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0); 0 = all-zeros word, 1 = all-ones word; up = 0..N-1, down = N-1..0.
REQ-020 SHALL issue exactly one memory operation per RUN cycle; r/w pairs on the same address in consecutive cycles; total 10N operations.
REQ-021 SHALL honour memory timing: write data is registered inside the memory, so mem_wdata SHALL hold the current element's write value and change no later than one cycle before that element's first write; SETUP drives M0's value.
REQ-022 SHALL honour two-cycle read latency: read issued in cycle t is compared against mem_rdata in cycle t+2 via a 2-stage pipeline carrying {valid, expected, address, element}.
REQ-023 FSM states IDLE, SETUP, RUN, DRAIN, DONE: IDLE->SETUP on start; SETUP->RUN after 1 cycle; RUN->DRAIN after last M5 read; DRAIN 2 cycles; DONE 1 cycle then IDLE.
REQ-024 With start high in cycle C0: SETUP C1, RUN C2..C(1+10N), DRAIN C(2+10N)..C(3+10N), done=1 and busy=0 in C(4+10N).
REQ-025 Outside RUN, mem_write_read SHALL be 0 and mem_address 0.
REQ-026 First miscompare SHALL load fail_addr/fail_elem/fail_exp/fail_act; later miscompares SHALL only increment error_count, which saturates at all-ones.
REQ-027 Test SHALL run to completion regardless of failures.
REQ-028 start while busy SHALL be ignored; start in SETUP of a new run SHALL clear fail, capture fields and error_count.
REQ-029 fail and capture fields SHALL hold after done until the next accepted start or reset.

Reset
REQ-030 rst SHALL force IDLE and set busy, done, fail, fail_addr, fail_elem, fail_exp, fail_act, error_count, mem_write_read, mem_address, mem_wdata and compare-pipeline valid bits to 0, including mid-run; in-flight reads SHALL be discarded.

Structure
REQ-031 Package mbist_pkg SHALL hold the FSM state encoding, element count (6), per-element direction/op-sequence/data constants.
REQ-032 Sub-module mbist_cmp SHALL implement the 2-stage compare pipeline, first-fail capture and saturating counter.

Verification
REQ-033 Fault-free 16-word memory, start pulse C0 -> done pulse in C164, fail=0, error_count=0.
REQ-034 Trace check -> C1 read addr 0 with mem_wdata=0x00; C2..C17 writes addr 0..15; C18 read addr 0, C19 write addr 0 with 0xFF; M3 begins at addr 15.
REQ-035 Bit1 of addr 5 stuck-at-1 -> fail=1, fail_addr=5, fail_elem=1, fail_exp=0x00, fail_act=0x02, error_count=3.
REQ-036 start asserted during RUN -> ignored, done still in C164 of the original run.
REQ-037 rst during M2 -> all outputs 0 next cycle, mem_write_read=0; fresh start completes in 164 cycles with fail=0.
REQ-038 error_count forced near saturation (CNT_WIDTH=2, all words stuck) -> error_count holds at 3.
